// File: rtl/vga_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_text_renderer
//  Purpose  : 80x30 text-mode pixel generator for 640x480 VGA timing; looks up
//             char RAM and font ROM and drives RGB444 with re-aligned syncs.
//             Optional blinking underline cursor: define VGA_TEXT_CURSOR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_text_renderer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  vga_x,
  input  logic [8:0]  vga_y,
  input  logic        video_on,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] rgb,
  output logic        hs_out,
  output logic        vs_out
);

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] bright;
    bright  = idx[3] ? 4'h5 : 4'h0;
    palette = {(idx[2] ? 4'hA : 4'h0) | bright,
               (idx[1] ? 4'hA : 4'h0) | bright,
               (idx[0] ? 4'hA : 4'h0) | bright};
  endfunction

  // S0: cell coordinates and char RAM address (row*80 = row*64 + row*16)
  logic [6:0]  col_s0;
  logic [4:0]  row_s0;
  logic [11:0] char_addr_d;
  logic        hit_d;

  assign col_s0      = vga_x[9:3];
  assign row_s0      = vga_y[8:4];
  assign char_addr_d = {1'b0, row_s0, 6'b0} + {3'b0, row_s0, 4'b0} + {5'b0, col_s0};
  assign char_addr   = rst ? 12'd0 : char_addr_d;

  // S1 state
  logic [2:0]  x1_q;
  logic [3:0]  y1_q;
  logic        von1_q;
  logic        hit1_q;
  logic        hs1_q;
  logic        vs1_q;

  // S2 state
  logic [2:0]  x2_q;
  logic [3:0]  fg2_q;
  logic [3:0]  bg2_q;
  logic        von2_q;
  logic        hit2_q;
  logic        hs2_q;
  logic        vs2_q;

  logic [11:0] rgb_q;
  logic        cursor_on;
  logic        pix_d;
  logic [3:0]  idx_d;
  logic [11:0] rgb_d;

  // char_data arrives during S1, so the font address is formed directly from it
  assign font_addr = rst ? 12'd0 : {char_data[7:0], y1_q};

  always_comb begin
    pix_d = font_data[3'd7 - x2_q] | cursor_on;
    idx_d = pix_d ? fg2_q : bg2_q;
    rgb_d = von2_q ? palette(idx_d) : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q   <= 3'd0;
      y1_q   <= 4'd0;
      von1_q <= 1'b0;
      hit1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      x2_q   <= 3'd0;
      fg2_q  <= 4'd0;
      bg2_q  <= 4'd0;
      von2_q <= 1'b0;
      hit2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      rgb_q  <= 12'h000;
    end else begin
      x1_q   <= vga_x[2:0];
      y1_q   <= vga_y[3:0];
      von1_q <= video_on;
      hit1_q <= hit_d;
      // Syncs already lag the coordinates by one cycle, so two stages suffice
      hs1_q  <= hs_in;
      vs1_q  <= vs_in;
      x2_q   <= x1_q;
      fg2_q  <= char_data[11:8];
      bg2_q  <= char_data[15:12];
      von2_q <= von1_q;
      hit2_q <= hit1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign rgb    = rgb_q;
  assign hs_out = hs2_q;
  assign vs_out = vs2_q;

`ifdef VGA_TEXT_CURSOR_EN
  localparam logic [BLINK_LOG2-1:0] c_cnt_one = BLINK_LOG2'(1);

  logic                  vs_prev_q;
  logic [BLINK_LOG2-1:0] frame_cnt_q;
  logic                  blink_q;

  // Underline occupies the bottom two scanlines of the cursor cell
  assign hit_d = (col_s0 == cursor_col) && (row_s0 == cursor_row) &&
                 (vga_y[3:1] == 3'b111);

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      vs_prev_q <= vs_in;
      if (vs_prev_q && !vs_in) begin
        frame_cnt_q <= frame_cnt_q + c_cnt_one;
        if (&frame_cnt_q) begin
          blink_q <= ~blink_q;
        end
      end
    end
  end

  assign cursor_on = hit2_q & blink_q;
`else
  logic unused_cursor;

  assign hit_d         = 1'b0;
  assign cursor_on     = 1'b0;
  assign unused_cursor = (^{cursor_col, cursor_row}) ^ (BLINK_LOG2 > 0);
`endif

  // Geometry is fixed by 640x480 timing; the parameters document it
  logic unused_geom;
  assign unused_geom = (COLS != 80) | (ROWS != 30);

endmodule
`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_text_renderer
//  Purpose  : Scoreboard bench for vga_text_renderer with char RAM / font ROM
//             models; cursor frames are checked when VGA_TEXT_CURSOR_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_text_renderer;

  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic        video_on;
  logic        hs_in;
  logic        vs_in;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] rgb;
  logic        hs_out;
  logic        vs_out;

  always #5 clk = ~clk;

  vga_text_renderer #(.COLS(80), .ROWS(30), .BLINK_LOG2(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .video_on   (video_on),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .rgb        (rgb),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  logic [15:0] char_mem [0:4095];
  logic [7:0]  font_rom [0:4095];

  always @(posedge clk) begin
    char_data <= char_mem[char_addr];
    font_data <= font_rom[font_addr];
  end

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic hs_next  = 1'b1;
  logic vs_next  = 1'b1;
  logic vs_drv_prev = 1'b1;
  int   frames   = 0;
  int   low_run  = 0;
  int   last_low = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pal(input logic [3:0] i);
    logic [3:0] r, g, b;
    r = (i[2] ? 4'hA : 4'h0) + (i[3] ? 4'h5 : 4'h0);
    g = (i[1] ? 4'hA : 4'h0) + (i[3] ? 4'h5 : 4'h0);
    b = (i[0] ? 4'hA : 4'h0) + (i[3] ? 4'h5 : 4'h0);
    return {r, g, b};
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input logic von, input int frm);
    logic [15:0] cd;
    logic [7:0]  fr;
    logic        pix;
    if (!von) return 12'h000;
    cd  = char_mem[(y / 16) * 80 + x / 8];
    fr  = font_rom[int'(cd[7:0]) * 16 + y % 16];
    pix = fr[7 - x % 8];
`ifdef VGA_TEXT_CURSOR_EN
    if (x / 8 == 2 && y / 16 == 2 && (y % 16) >= 14 && ((frm >> BL) & 1) == 1) pix = 1'b1;
`else
    if (frm < 0) pix = 1'b0;
`endif
    return pal(pix ? cd[11:8] : cd[15:12]);
  endfunction

  task automatic step(input int x, input int y, input logic von,
                      input logic hs, input logic vs, input logic r);
    exp_t e;
    int   a;
    rst      = r;
    vga_x    = 10'(x);
    vga_y    = 9'(y);
    video_on = von;
    a        = (y / 16) * 80 + x / 8;
    if (r) begin
      hs_in = 1'b0;
      vs_in = 1'b0;
      hs_next = 1'b1;
      vs_next = 1'b1;
      vs_drv_prev = 1'b1;
      frames = 0;
      exp_q.delete();
    end else begin
      hs_in = hs_next;
      vs_in = vs_next;
      if (vs_drv_prev && !vs_next) frames++;
      vs_drv_prev = vs_next;
      hs_next = hs;
      vs_next = vs;
      e.rgb = model_rgb(x, y, von, frames);
      e.hs  = hs;
      e.vs  = vs;
      exp_q.push_back(e);
    end
    #1;
    check_eq("char_addr", 32'(char_addr), r ? 32'd0 : 32'(a));
    @(posedge clk);
    #1;
    if (r) begin
      check_eq("rst_rgb", 32'(rgb), 32'h0);
      check_eq("rst_hs", 32'(hs_out), 32'h1);
      check_eq("rst_vs", 32'(vs_out), 32'h1);
      check_eq("rst_font_addr", 32'(font_addr), 32'h0);
    end else begin
      check_eq("font_addr", 32'(font_addr), (int'(char_mem[a][7:0]) * 16) + (y % 16));
      if (exp_q.size() >= 3) begin
        e = exp_q.pop_front();
        check_eq("rgb", 32'(rgb), 32'(e.rgb));
        check_eq("hs_out", 32'(hs_out), 32'(e.hs));
        check_eq("vs_out", 32'(vs_out), 32'(e.vs));
      end else begin
        check_eq("flush_rgb", 32'(rgb), 32'h0);
      end
    end
    if (hs_out == 1'b0) begin
      low_run++;
    end else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end
  endtask

  initial begin
    rst = 1'b1; vga_x = '0; vga_y = '0; video_on = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1;
    cursor_col = 7'd2; cursor_row = 5'd2;
    for (int i = 0; i < 4096; i++) begin
      char_mem[i] = 16'($urandom);
      font_rom[i] = 8'($urandom);
    end
    char_mem[0]   = 16'h0FFF;
    char_mem[162] = 16'h1F41;
    char_mem[163] = 16'h1F41;
    for (int i = 0; i < 16; i++) font_rom[255 * 16 + i] = 8'hFF;
    font_rom[12'h413] = 8'b0100_0000;
    font_rom[12'h41E] = 8'h00;
    font_rom[12'h41F] = 8'h00;

    // Reset held for 4 cycles
    for (int i = 0; i < 4; i++) step(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Row containing cell (2,2) at y=35, then cell 0 active and blanked
    for (int x = 0; x < 48; x++) step(x, 35, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int x = 0; x < 16; x++) step(x, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int x = 0; x < 16; x++) step(x, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random coordinates
    for (int i = 0; i < 40; i++)
      step(int'($urandom_range(639)), int'($urandom_range(479)), 1'b1, 1'b1, 1'b1, 1'b0);

    // Horizontal sync pulse of 96 cycles during blanking
    for (int i = 0; i < 96; i++) step(i, 36, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(96 + i, 36, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-line during active pixels, then refill
    for (int x = 200; x < 210; x++) step(x, 100, 1'b1, 1'b1, 1'b1, 1'b0);
    step(210, 100, 1'b1, 1'b1, 1'b1, 1'b1);
    step(211, 100, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int x = 212; x < 240; x++) step(x, 100, 1'b1, 1'b1, 1'b1, 1'b0);

    // Mini frames: cursor cell (2,2) and neighbour (3,2) on scanline y[3:0]=15
    for (int f = 0; f < 6; f++) begin
      for (int x = 16; x < 32; x++) step(x, 47, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(i, 48, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(i, 48, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(i, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    for (int i = 0; i < 6; i++) step(i, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("hs_width", 32'(last_low), 32'd96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
